// File: rtl/fc_pkg.sv
// rtl/fc_pkg.sv - shared state encoding and default widths for the fc layer sequencer
package fc_pkg;

  localparam int FC_IN_DATA_WIDTH = 8;
  localparam int FC_RESULT_WIDTH  = 4 * FC_IN_DATA_WIDTH;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    CLR   = 3'd1,
    ISSUE = 3'd2,
    DRAIN = 3'd3,
    OUT   = 3'd4,
    DONE  = 3'd5
  } state_t;

endpackage

// File: rtl/fc_layer_sequencer_if.sv
// rtl/fc_layer_sequencer_if.sv - neuron result valid/ready port
interface fc_layer_sequencer_if
  import fc_pkg::*;
#(
  parameter int IN_DATA_WIDTH = FC_IN_DATA_WIDTH,
  parameter int BIAS_AW       = 2
);
  logic                       o_result_valid;
  logic                       i_result_ready;
  logic [4*IN_DATA_WIDTH-1:0] o_result;
  logic [BIAS_AW-1:0]         o_result_idx;

  modport master (
    output o_result_valid,
    output o_result,
    output o_result_idx,
    input  i_result_ready
  );

  modport slave (
    input  o_result_valid,
    input  o_result,
    input  o_result_idx,
    output i_result_ready
  );
endinterface

// File: rtl/fc_layer_sequencer.sv
// rtl/fc_layer_sequencer.sv - streams nodes/weights/bias into the fc core one neuron at a time
module fc_layer_sequencer
  import fc_pkg::*;
#(
  parameter int IN_DATA_WIDTH = FC_IN_DATA_WIDTH,
  parameter int IN_NODE       = 16,
  parameter int OUT_NODE      = 4,
  parameter int NODE_AW       = (IN_NODE > 1) ? $clog2(IN_NODE) : 1,
  parameter int WGT_AW        = (IN_NODE * OUT_NODE > 1) ? $clog2(IN_NODE * OUT_NODE) : 1,
  parameter int BIAS_AW       = (OUT_NODE > 1) ? $clog2(OUT_NODE) : 1
) (
  input  logic                       clk,
  input  logic                       reset_n,
  input  logic                       i_start,
  output logic                       o_busy,
  output logic                       o_done,
  output logic [NODE_AW-1:0]         o_node_addr,
  input  logic [IN_DATA_WIDTH-1:0]   i_node_data,
  output logic [WGT_AW-1:0]          o_wegt_addr,
  input  logic [IN_DATA_WIDTH-1:0]   i_wegt_data,
  output logic [BIAS_AW-1:0]         o_bias_addr,
  input  logic [IN_DATA_WIDTH-1:0]   i_bias_data,
  output logic                       o_core_run,
  output logic                       o_core_valid,
  output logic [IN_DATA_WIDTH-1:0]   o_core_node,
  output logic [IN_DATA_WIDTH-1:0]   o_core_wegt,
  output logic [IN_DATA_WIDTH-1:0]   o_core_bias,
  input  logic [4*IN_DATA_WIDTH-1:0] i_core_result,
  fc_layer_sequencer_if.master       res
);

  localparam logic [NODE_AW-1:0] K_LAST = NODE_AW'(IN_NODE - 1);
  localparam logic [BIAS_AW-1:0] N_LAST = BIAS_AW'(OUT_NODE - 1);
  localparam logic [WGT_AW-1:0]  W_STEP = WGT_AW'(IN_NODE);

  state_t                     state, next_state;
  logic [NODE_AW-1:0]         k;
  logic [BIAS_AW-1:0]         n;
  logic [WGT_AW-1:0]          wbase;
  logic                       drain_last;
  logic                       valid_d, first_d;
  logic [4*IN_DATA_WIDTH-1:0] result_q;
  logic [BIAS_AW-1:0]         result_idx_q;

  always_ff @(posedge clk) begin
    if (!reset_n) state <= IDLE;
    else          state <= next_state;
  end

  always_comb begin
    next_state         = state;
    o_busy             = (state != IDLE);
    o_done             = 1'b0;
    o_core_run         = 1'b0;
    res.o_result_valid = 1'b0;
    case (state)
      IDLE:  if (i_start) next_state = CLR;
      CLR: begin
        o_core_run = 1'b1;
        next_state = ISSUE;
      end
      ISSUE: if (k == K_LAST) next_state = DRAIN;
      DRAIN: if (drain_last) next_state = OUT;
      OUT: begin
        res.o_result_valid = 1'b1;
        if (res.i_result_ready) next_state = (n == N_LAST) ? DONE : CLR;
      end
      DONE: begin
        o_done     = 1'b1;
        next_state = IDLE;
      end
      default: next_state = IDLE;
    endcase
  end

  // Counters only move in their own states, so addresses stay frozen under backpressure.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      k            <= '0;
      n            <= '0;
      wbase        <= '0;
      drain_last   <= 1'b0;
      valid_d      <= 1'b0;
      first_d      <= 1'b0;
      result_q     <= '0;
      result_idx_q <= '0;
    end else begin
      valid_d <= (state == ISSUE);
      first_d <= (state == ISSUE) && (k == '0);
      case (state)
        IDLE: begin
          if (i_start) begin
            n     <= '0;
            wbase <= '0;
            k     <= '0;
          end
        end
        CLR: begin
          k          <= '0;
          drain_last <= 1'b0;
        end
        ISSUE: if (k != K_LAST) k <= k + NODE_AW'(1);
        DRAIN: begin
          drain_last <= 1'b1;
          if (drain_last) begin
            result_q     <= i_core_result;
            result_idx_q <= n;
          end
        end
        OUT: begin
          if (res.i_result_ready && (n != N_LAST)) begin
            n     <= n + BIAS_AW'(1);
            wbase <= wbase + W_STEP;
          end
        end
        default: ;
      endcase
    end
  end

  assign o_node_addr = k;
  assign o_wegt_addr = wbase + WGT_AW'(k);
  assign o_bias_addr = n;

  // Core adds the bias operand on every valid beat, so only the first beat carries it.
  assign o_core_valid = valid_d;
  assign o_core_node  = valid_d ? i_node_data : '0;
  assign o_core_wegt  = valid_d ? i_wegt_data : '0;
  assign o_core_bias  = first_d ? i_bias_data : '0;

  assign res.o_result     = result_q;
  assign res.o_result_idx = result_idx_q;

endmodule

// File: tb/tb_fc_layer_sequencer.sv
// tb/tb_fc_layer_sequencer.sv - randomized self-checking bench with a behavioural layer model
module tb_fc_layer_sequencer;
  import fc_pkg::*;

  localparam int W        = 8;
  localparam int IN_NODE  = 4;
  localparam int OUT_NODE = 2;
  localparam int NODE_AW  = 2;
  localparam int WGT_AW   = 3;
  localparam int BIAS_AW  = 1;
  localparam int RW       = 4 * W;

  logic               clk = 1'b0;
  logic               reset_n = 1'b0;
  logic               start = 1'b0;
  logic               busy, done;
  logic [NODE_AW-1:0] node_addr;
  logic [WGT_AW-1:0]  wegt_addr;
  logic [BIAS_AW-1:0] bias_addr;
  logic [W-1:0]       node_q = '0, wegt_q = '0, bias_q = '0;
  logic               core_run, core_valid;
  logic [W-1:0]       core_node, core_wegt, core_bias;
  logic [RW-1:0]      acc = '0;

  fc_layer_sequencer_if #(.IN_DATA_WIDTH(W), .BIAS_AW(BIAS_AW)) res ();

  fc_layer_sequencer #(
    .IN_DATA_WIDTH(W), .IN_NODE(IN_NODE), .OUT_NODE(OUT_NODE),
    .NODE_AW(NODE_AW), .WGT_AW(WGT_AW), .BIAS_AW(BIAS_AW)
  ) dut (
    .clk(clk), .reset_n(reset_n), .i_start(start), .o_busy(busy), .o_done(done),
    .o_node_addr(node_addr), .i_node_data(node_q),
    .o_wegt_addr(wegt_addr), .i_wegt_data(wegt_q),
    .o_bias_addr(bias_addr), .i_bias_data(bias_q),
    .o_core_run(core_run), .o_core_valid(core_valid),
    .o_core_node(core_node), .o_core_wegt(core_wegt), .o_core_bias(core_bias),
    .i_core_result(acc), .res(res)
  );

  always #5 clk = ~clk;

  logic [W-1:0] node_mem [IN_NODE];
  logic [W-1:0] wgt_mem  [IN_NODE*OUT_NODE];
  logic [W-1:0] bias_mem [OUT_NODE];

  // Synchronous-read memories and an accumulating core
  always @(posedge clk) begin
    node_q <= node_mem[node_addr];
    wegt_q <= wgt_mem[wegt_addr];
    bias_q <= bias_mem[bias_addr];
    if (!reset_n)        acc <= '0;
    else if (core_run)   acc <= '0;
    else if (core_valid) acc <= acc + RW'(core_node) * RW'(core_wegt) + RW'(core_bias);
  end

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int total = 0, bad = 0;

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0d exp=%0d (t=%0t)", name, got, exp, $time);
    end
  endtask

  function automatic logic [RW-1:0] model_sum(input int n);
    logic [RW-1:0] s;
    s = RW'(bias_mem[n]);
    for (int k = 0; k < IN_NODE; k++)
      s = s + RW'(node_mem[k]) * RW'(wgt_mem[n*IN_NODE + k]);
    return s;
  endfunction

  typedef struct { logic [RW-1:0] sum; int idx; } exp_t;
  exp_t          exp_q[$];
  logic [RW-1:0] got_q[$];
  int            ref_cyc = 0, model_n = 0, elem = 0, run_cnt = 0, dones = 0;
  logic          prev_valid = 1'b0, bp_prev = 1'b0, rand_ready = 1'b0;
  logic [RW-1:0] prev_res;
  logic [BIAS_AW-1:0] prev_idx;
  logic [NODE_AW-1:0] prev_na;
  logic [WGT_AW-1:0]  prev_wa;

  always @(posedge clk) begin
    #1;
    if (rand_ready) res.i_result_ready = 1'($urandom_range(0, 1));
  end

  // Per-cycle comparison of DUT outputs against the layer model
  always @(negedge clk) begin
    if (reset_n) begin
      if (core_run) begin
        run_cnt++;
        elem = 0;
      end
      if (core_valid) begin
        if (elem < IN_NODE && model_n < OUT_NODE) begin
          check("core_node", core_node, node_mem[elem]);
          check("core_wegt", core_wegt, wgt_mem[model_n*IN_NODE + elem]);
          check("core_bias", core_bias, (elem == 0) ? bias_mem[model_n] : '0);
        end else
          check("core_valid_extra", 1, 0);
        elem++;
      end
      check("done_and_valid", done & res.o_result_valid, 0);
      if (bp_prev) begin
        check("bp_result_hold", res.o_result, prev_res);
        check("bp_idx_hold", res.o_result_idx, prev_idx);
        check("bp_addr_hold", {node_addr, wegt_addr}, {prev_na, prev_wa});
        check("bp_no_core", {core_run, core_valid}, 0);
      end
      if (res.o_result_valid && !prev_valid)
        check("valid_latency", cyc - ref_cyc, IN_NODE + 4);
      if (res.o_result_valid && res.i_result_ready) begin
        if (exp_q.size() == 0) check("result_unexpected", 1, 0);
        else begin
          exp_t e;
          e = exp_q.pop_front();
          check("result_sum", res.o_result, e.sum);
          check("result_idx", res.o_result_idx, e.idx);
        end
        got_q.push_back(res.o_result);
        ref_cyc = cyc;
        model_n++;
      end
      if (done) dones++;
      bp_prev    = res.o_result_valid && !res.i_result_ready;
      prev_valid = res.o_result_valid;
      prev_res   = res.o_result;
      prev_idx   = res.o_result_idx;
      prev_na    = node_addr;
      prev_wa    = wegt_addr;
    end else begin
      bp_prev    = 1'b0;
      prev_valid = 1'b0;
    end
  end

  task automatic check_idle_outputs(input string tag);
    check({tag, "_busy"}, busy, 0);
    check({tag, "_done"}, done, 0);
    check({tag, "_addrs"}, {node_addr, wegt_addr, bias_addr}, 0);
    check({tag, "_core_ctl"}, {core_run, core_valid}, 0);
    check({tag, "_core_ops"}, {core_node, core_wegt, core_bias}, 0);
    check({tag, "_res_valid"}, res.o_result_valid, 0);
    check({tag, "_result"}, {res.o_result, res.o_result_idx}, 0);
  endtask

  task automatic launch();
    @(negedge clk);
    start = 1'b1;
    ref_cyc = cyc;
    model_n = 0;
    run_cnt = 0;
    dones = 0;
    got_q.delete();
    for (int n = 0; n < OUT_NODE; n++) exp_q.push_back('{model_sum(n), n});
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_done(input string tag);
    int t;
    t = 0;
    while (dones == 0 && t < 500) begin
      @(posedge clk);
      t++;
    end
    if (dones == 0) check({tag, "_timeout"}, 1, 0);
    repeat (3) @(negedge clk);
    check({tag, "_results"}, got_q.size(), OUT_NODE);
    check({tag, "_dones"}, dones, 1);
    check({tag, "_run_cycles"}, run_cnt, OUT_NODE);
    check({tag, "_idle"}, busy, 0);
  endtask

  task automatic load_plan();
    node_mem = '{8'd1, 8'd2, 8'd3, 8'd4};
    wgt_mem  = '{8'd1, 8'd1, 8'd1, 8'd1, 8'd2, 8'd0, 8'd0, 8'd1};
    bias_mem = '{8'd5, 8'd10};
  endtask

  task automatic check_plan_literals(input string tag);
    if (got_q.size() == 2) begin
      check({tag, "_lit0"}, got_q[0], 15);
      check({tag, "_lit1"}, got_q[1], 16);
    end else
      check({tag, "_lit_count"}, got_q.size(), 2);
  endtask

  task automatic wait_valid(input string tag);
    int t;
    t = 0;
    while (!res.o_result_valid && t < 100) begin
      @(negedge clk);
      t++;
    end
    if (!res.o_result_valid) check({tag, "_valid_timeout"}, 1, 0);
  endtask

  initial begin
    res.i_result_ready = 1'b1;
    load_plan();
    repeat (3) @(negedge clk);
    check_idle_outputs("reset");
    reset_n = 1'b1;
    @(negedge clk);

    // Hand-computed plan, ready tied high
    launch();
    wait_done("plan");
    check_plan_literals("plan");

    // Backpressure on the first result
    res.i_result_ready = 1'b0;
    launch();
    wait_valid("bp");
    check("bp_lit", res.o_result, 15);
    repeat (4) @(negedge clk);
    check("bp_lit_held", res.o_result, 15);
    res.i_result_ready = 1'b1;
    wait_done("bp");
    check_plan_literals("bp");

    // Full-scale operands
    for (int i = 0; i < IN_NODE; i++) node_mem[i] = 8'd255;
    for (int i = 0; i < IN_NODE*OUT_NODE; i++) wgt_mem[i] = 8'd255;
    for (int i = 0; i < OUT_NODE; i++) bias_mem[i] = 8'd255;
    launch();
    wait_done("max");
    if (got_q.size() > 0) check("max_lit", got_q[0], 260355);

    // Start pulses while busy are ignored
    load_plan();
    res.i_result_ready = 1'b0;
    launch();
    repeat (3) @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wait_valid("ign");
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    res.i_result_ready = 1'b1;
    wait_done("ign");
    check_plan_literals("ign");

    // Reset during ISSUE of the second neuron, then a clean restart
    launch();
    begin
      int t;
      t = 0;
      while (run_cnt < 2 && t < 100) begin
        @(posedge clk);
        t++;
      end
      if (run_cnt < 2) check("rst_wait_timeout", 1, 0);
    end
    repeat (2) @(negedge clk);
    reset_n = 1'b0;
    @(negedge clk);
    check_idle_outputs("midrst");
    @(negedge clk);
    exp_q.delete();
    reset_n = 1'b1;
    @(negedge clk);
    launch();
    wait_done("restart");
    check_plan_literals("restart");

    // Randomized layers with random backpressure
    rand_ready = 1'b1;
    for (int r = 0; r < 8; r++) begin
      for (int i = 0; i < IN_NODE; i++) node_mem[i] = 8'($urandom);
      for (int i = 0; i < IN_NODE*OUT_NODE; i++) wgt_mem[i] = 8'($urandom);
      for (int i = 0; i < OUT_NODE; i++) bias_mem[i] = 8'($urandom);
      launch();
      wait_done("rand");
    end
    rand_ready = 1'b0;
    res.i_result_ready = 1'b1;
    check("queue_empty", exp_q.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/fc_layer_sequencer.md
# fc_layer_sequencer

Controller that runs one fully-connected layer on the `fully_connected_core` MAC/accumulator. It fetches input nodes, weights and biases from three synchronous read memories and streams them into the core, one output neuron at a time. Per neuron it clears the core, waits for the final sum and returns it over a valid/ready result port. Sits beside the core in `fc_core_top`, between the layer memories and the downstream result sink.

## Interface

Parameters:
- `IN_DATA_WIDTH`, 8: node/weight/bias width; result width is 4*IN_DATA_WIDTH
- `IN_NODE`, 16: inputs per neuron, ≥1
- `OUT_NODE`, 4: neurons per layer, ≥1
- `NODE_AW`, $clog2(IN_NODE) (min 1): node address width
- `WGT_AW`, $clog2(IN_NODE*OUT_NODE) (min 1): weight address width
- `BIAS_AW`, $clog2(OUT_NODE) (min 1): bias address width

Ports:
- `clk` in 1: single clock, all logic on posedge
- `reset_n` in 1: synchronous, active-low reset
- `i_start` in 1: start layer; sampled in IDLE only
- `o_busy` out 1: high in every state except IDLE
- `o_done` out 1: one-cycle pulse after last result accepted
- `o_node_addr` out NODE_AW: node memory address
- `i_node_data` in IN_DATA_WIDTH: node memory read data, 1-cycle latency
- `o_wegt_addr` out WGT_AW: weight memory address
- `i_wegt_data` in IN_DATA_WIDTH: weight read data, 1-cycle latency
- `o_bias_addr` out BIAS_AW: bias memory address
- `i_bias_data` in IN_DATA_WIDTH: bias read data, 1-cycle latency
- `o_core_run` out 1: core clear
- `o_core_valid` out 1: core accumulate enable
- `o_core_node`, `o_core_wegt`, `o_core_bias` out IN_DATA_WIDTH each: core operands
- `i_core_result` in 4*IN_DATA_WIDTH: core accumulator
- `o_result_valid` out 1: result available
- `i_result_ready` in 1: sink accepts result
- `o_result` out 4*IN_DATA_WIDTH: neuron sum, unsigned
- `o_result_idx` out BIAS_AW: neuron index of `o_result`

## Operation

- States: IDLE, CLR, ISSUE, DRAIN, OUT, DONE.
- IDLE: if `i_start`, go to CLR with neuron counter n=0. `i_start` is ignored in all other states.
- CLR (1 cycle): `o_core_run`=1, element counter k=0, go to ISSUE.
- ISSUE (IN_NODE cycles): drive `o_node_addr`=k and `o_wegt_addr`=n*IN_NODE+k; `o_bias_addr`=n. Increment k. After k=IN_NODE-1, go to DRAIN.
- Issue flag and first flag (k==0) are registered one cycle to align with memory latency.
  - `o_core_valid` = delayed issue flag.
  - `o_core_node` = `i_node_data`; `o_core_wegt` = `i_wegt_data`.
  - `o_core_bias` = `i_bias_data` when delayed first flag is set, else 0. The core adds bias on every valid cycle, so bias must enter exactly once per neuron.
- DRAIN (2 cycles): cycle 1 carries the last `o_core_valid`; cycle 2 sees the final core sum. At the end of cycle 2, register `i_core_result` into `o_result` and n into `o_result_idx`, then go to OUT.
- OUT: `o_result_valid`=1. When `i_result_ready`=1, either go to CLR with n+1, or to DONE if n==OUT_NODE-1.
- DONE (1 cycle): `o_done`=1, then IDLE.
- Arithmetic is unsigned and performed by the core. The sequencer does not modify the sum. Weight layout in memory is neuron-major.

## Timing

- Reset values: all outputs 0; state IDLE; counters 0.
- Reset asserted in any state returns to IDLE on the next edge and drops all outputs. A partial result is discarded.
- Latency, with the start-accept cycle as cycle 0:
  - CLR: cycle 1
  - ISSUE: cycles 2..IN_NODE+1
  - core valid: cycles 3..IN_NODE+2
  - DRAIN: cycles IN_NODE+2..IN_NODE+3
  - `o_result_valid` rises: cycle IN_NODE+4
- Each later neuron takes IN_NODE+4 cycles from the accepting handshake to the next `o_result_valid`.
- Backpressure: while `i_result_ready`=0 in OUT, `o_result` and `o_result_idx` are held stable, and no memory or core activity occurs.
- Ready may be high before valid; the handshake completes on the first cycle with both high. OUT therefore lasts at least 1 cycle.
- IN_NODE=1: ISSUE is 1 cycle, and the same element is both first and last.
- `o_done` and `o_result_valid` are never high in the same cycle.

## Structure

- Shared package `fc_pkg`:
  - state enum (IDLE, CLR, ISSUE, DRAIN, OUT, DONE)
  - default width constants: IN_DATA_WIDTH, result width = 4*IN_DATA_WIDTH
- No sub-module. Counters, address generation and alignment registers stay in this block.
- `fully_connected_core` is instantiated next to it in `fc_core_top`, not inside it.

## Test plan

- IN_NODE=4, OUT_NODE=2; nodes [1,2,3,4]; weights n0 [1,1,1,1], n1 [2,0,0,1]; bias [5,10]; ready tied 1 → results (idx0, 15) then (idx1, 16); `o_done` pulses once; bias applied once per neuron.
- Same setup → first `o_result_valid` at cycle 8 after start accept; second at cycle 8 after first handshake; `o_core_run` high exactly 2 cycles total.
- Ready held low 5 cycles on the first result → `o_result`=15 stable, no CLR, no address change; second result follows correctly once ready rises.
- All nodes and weights 255, bias 255, IN_NODE=4 → `o_result`=260355, no truncation.
- `i_start` pulsed during ISSUE and OUT → ignored; exactly OUT_NODE results, one `o_done`.
- `reset_n` low during ISSUE of n1 → next edge: IDLE, all outputs 0. A restart then yields 15 and 16.
